// File: rtl/twiddle_addr_sequencer_pkg.sv
// Shared constants, stage table, beat payload type and bit-reverse helper for the
// IFFT twiddle address sequencer. Optional feature macro: TW_SEQ_BITREV_EN.
package twiddle_seq_pkg;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned N_STAGES    = 5;
    localparam int unsigned STAGE_W     = 3;
    localparam int unsigned REP_W       = 4;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned FRAME_BEATS = 160;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Imaginary-part twiddle ROM layout, packed stage by stage (28 entries used).
    localparam logic [ADDR_W-1:0] STAGE_BASE [N_STAGES] = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd20};
    localparam logic [LEN_W-1:0]  STAGE_LEN  [N_STAGES] = '{4'd4, 4'd4, 4'd4, 4'd8, 4'd8};
    localparam logic [REP_W-1:0]  STAGE_REP  [N_STAGES] = '{4'd8, 4'd8, 4'd8, 4'd4, 4'd4};

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

    // Beat descriptor registered alongside the presented ROM word.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [STAGE_W-1:0] stage;
        logic               last;
        logic               frame_last;
    } beat_t;

    // Reverse the in-stage index over log2(len) bits.
    function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] idx,
                                                input logic [LEN_W-1:0] len);
        logic [IDX_W-1:0] res;
        res = idx;
        if (len == 4'd8) begin
            res = {idx[0], idx[1], idx[2]};
        end else if (len == 4'd4) begin
            res = {1'b0, idx[0], idx[1]};
        end
        return res;
    endfunction

endpackage

// File: rtl/twiddle_addr_sequencer_if.sv
// Control, ROM-address and twiddle handshake bundle between the IFFT control,
// the twiddle sequencer and the butterfly datapath.
interface twiddle_addr_sequencer_if;
    import twiddle_seq_pkg::*;

    logic               start;
    logic               abort;
    logic               busy;
    logic               frame_done;
    logic [ADDR_W-1:0]  rom_addr;
    logic               tw_valid;
    logic [STAGE_W-1:0] tw_stage;
    logic               tw_last;
    logic               tw_ready;

    modport master (
        input  start, abort, tw_ready,
        output busy, frame_done, rom_addr, tw_valid, tw_stage, tw_last
    );

    modport slave (
        output start, abort, tw_ready,
        input  busy, frame_done, rom_addr, tw_valid, tw_stage, tw_last
    );

endinterface

// File: rtl/twiddle_addr_sequencer_beat_counter.sv
// Nested stage / index / repeat counters describing the next beat to issue.
// Wraps back to beat 0 after the final beat of the frame.
module tw_beat_counter
    import twiddle_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [STAGE_W-1:0] stage,
    output logic [IDX_W-1:0]   idx,
    output logic               stage_last_c,
    output logic               frame_last_c
);

    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [IDX_W-1:0]   idx_last_c;
    logic               rep_last_c;

    // Bounds of the current stage.
    always_comb begin
        idx_last_c   = IDX_W'(STAGE_LEN[stage_q] - LEN_W'(1));
        rep_last_c   = (rep_q == (STAGE_REP[stage_q] - REP_W'(1)));
        stage_last_c = rep_last_c && (idx_q == idx_last_c);
        frame_last_c = stage_last_c && (stage_q == LAST_STAGE);
    end

    always_comb begin
        stage_d = stage_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        if (clear) begin
            stage_d = '0;
            idx_d   = '0;
            rep_d   = '0;
        end else if (advance) begin
            if (!rep_last_c) begin
                rep_d = rep_q + REP_W'(1);
            end else begin
                rep_d = '0;
                if (idx_q != idx_last_c) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d   = '0;
                    stage_d = frame_last_c ? '0 : stage_q + STAGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
        end else begin
            stage_q <= stage_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
        end
    end

    assign stage = stage_q;
    assign idx   = idx_q;

endmodule

// File: rtl/twiddle_addr_sequencer.sv
// IFFT imaginary-twiddle ROM address sequencer: FSM plus ROM-latency alignment.
// Define TW_SEQ_BITREV_EN to walk each stage's twiddles in bit-reversed index order.
module twiddle_addr_sequencer
    import twiddle_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    twiddle_addr_sequencer_if.master   bus
);

    state_t             state_q, state_d;
    beat_t              beat_q, beat_d;
    logic               tw_valid_q, tw_valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    logic               active_c;
    logic               accept_c;
    logic               adv_c;
    logic               cnt_clear_c;
    logic [STAGE_W-1:0] cnt_stage;
    logic [IDX_W-1:0]   cnt_idx;
    logic               cnt_stage_last_c;
    logic               cnt_frame_last_c;
    logic [IDX_W-1:0]   idx_eff_c;
    logic [ADDR_W-1:0]  next_addr_c;

    assign active_c    = (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign accept_c    = (state_q == ST_RUN) && tw_valid_q && bus.tw_ready;
    assign adv_c       = (state_q == ST_PRIME) || accept_c;
    assign cnt_clear_c = !active_c || bus.abort;

    tw_beat_counter u_beat_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear_c),
        .advance      (adv_c),
        .stage        (cnt_stage),
        .idx          (cnt_idx),
        .stage_last_c (cnt_stage_last_c),
        .frame_last_c (cnt_frame_last_c)
    );

`ifdef TW_SEQ_BITREV_EN
    assign idx_eff_c = bit_rev(cnt_idx, STAGE_LEN[cnt_stage]);
`else
    assign idx_eff_c = cnt_idx;
`endif

    assign next_addr_c = STAGE_BASE[cnt_stage] + ADDR_W'(idx_eff_c);

    // Re-read the presented entry while stalled so the ROM output holds still.
    assign bus.rom_addr = adv_c ? next_addr_c : beat_q.addr;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        tw_valid_d   = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                state_d = bus.abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (accept_c && beat_q.frame_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Beat tags follow the address issued to the ROM one cycle earlier.
        if (active_c && bus.abort) begin
            beat_d = '0;
        end else if (adv_c) begin
            beat_d.addr       = next_addr_c;
            beat_d.stage      = cnt_stage;
            beat_d.last       = cnt_stage_last_c;
            beat_d.frame_last = cnt_frame_last_c;
        end

        tw_valid_d   = (state_d == ST_RUN);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            tw_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            tw_valid_q   <= tw_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tw_valid   = tw_valid_q;
    assign bus.tw_stage   = beat_q.stage;
    assign bus.tw_last    = beat_q.last;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/twiddle_addr_sequencer.md
Name: twiddle_addr_sequencer

Overview:
Controller for the IFFT imaginary-part twiddle ROM: a synchronous 32x16 ROM with 1-cycle read latency and 28 used entries, packed stage by stage.
- On a frame start, walks every stage's twiddle slice, repeating each twiddle once per butterfly that consumes it.
- Drives the ROM address so that the ROM output is valid and aligned with tw_valid.
- Tags each output word with stage and last flags, honouring a valid/ready handshake from the butterfly datapath.
- Sits between the IFFT top-level control and the twiddle ROM / butterfly unit.

Parameters:
ADDR_W, 5, ROM address width.
N_STAGES, 5, number of IFFT stages sequenced per frame.
STAGE_W, 3, width of the stage index (ceil log2 N_STAGES).
REP_W, 4, width of the per-twiddle repeat counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; begins a frame when idle.
abort  in  1  terminates the current frame.
tw_ready  in  1  datapath accepts the current twiddle.
rom_addr  out  ADDR_W  address to the twiddle ROM (combinational, see Behaviour).
tw_valid  out  1  ROM output on this cycle is a valid twiddle.
tw_stage  out  STAGE_W  stage of the presented twiddle.
tw_last  out  1  presented twiddle is the final beat of its stage.
frame_done  out  1  one-cycle pulse after the final beat of the frame is accepted.
busy  out  1  high from the accepted start until frame_done or abort.

Behaviour:
- Reset (synchronous, rst=1): state IDLE; all registered state cleared; rom_addr=0, tw_valid=0, tw_stage=0, tw_last=0, frame_done=0, busy=0. Reset mid-frame discards the frame with no frame_done pulse.
- Stage table, from the package:
  - base = {0,4,8,12,20}
  - len = {4,4,4,8,8}
  - rep = {8,8,8,4,4}
  - Each stage therefore issues 32 beats; a frame is 160 beats.
- Beat order: for stage s = 0..4, for index i = 0..len-1, for repeat r = 0..rep-1, issue address base[s]+i.
- FSM states and transitions:
  - IDLE → PRIME on start.
  - PRIME → RUN after one cycle. PRIME issues the first address; the ROM needs a cycle before its output is valid.
  - RUN → DONE when the final beat (s=4, i=7, r=3) is accepted (tw_valid & tw_ready).
  - DONE → IDLE after one cycle. frame_done=1 for that single cycle.
- Address alignment:
  - cur_addr register holds the address whose ROM data is currently presented.
  - adv = PRIME | (RUN & tw_valid & tw_ready).
  - rom_addr = adv ? next_addr : cur_addr. Under stall the ROM keeps re-reading the same entry, so the ROM output is stable while tw_valid & !tw_ready.
- tw_valid: 1 throughout RUN, 0 in IDLE, PRIME and DONE.
  - Latency: first valid twiddle appears 2 cycles after start.
  - With tw_ready held high, one beat per cycle; frame_done is asserted 162 cycles after start.
- tw_stage and tw_last are registered alongside cur_addr and always describe the presented beat. tw_last=1 when i=len-1 and r=rep-1.
- start while busy: ignored.
- start and abort in the same cycle while IDLE: abort wins and start is ignored.
- abort in PRIME or RUN: next cycle enters IDLE; tw_valid=0, busy=0, no frame_done.
- tw_ready while tw_valid=0: ignored.
- Counters: r wraps to 0 and increments i; i wraps to 0 and increments s; no counter ever exceeds its stage bound.

Optional Feature:
Macro: TW_SEQ_BITREV_EN.
- Defined: the in-stage index is bit-reversed over log2(len[s]) bits before adding base (len 4: 0,2,1,3; len 8: 0,4,2,6,1,5,3,7). Repeat, stage and last semantics are unchanged; tw_last still marks the final beat of the stage.
- Undefined: natural index order.

Decomposition:
- Package twiddle_seq_pkg holds:
  - the state enum (IDLE, PRIME, RUN, DONE);
  - the constant arrays STAGE_BASE, STAGE_LEN, STAGE_REP;
  - the constants N_STAGES and FRAME_BEATS=160;
  - a bit-reverse function.
- One sub-module is natural: tw_beat_counter, holding the nested s/i/r counters with an advance input and wrap/last outputs. The FSM and address alignment stay in the top.

Test Plan:
- Reset, then start with tw_ready=1: tw_valid rises 2 cycles after start. Addresses seen are 0×8, 1×8, 2×8, 3×8, 4×8, and so on up to 27×4. frame_done 162 cycles after start. 160 accepted beats in total.
- Random tw_ready (50%) stall: the ROM output and tw_stage stay constant while stalled. The accepted address sequence is identical to the no-stall case, and rom_addr equals cur_addr whenever stalled.
- Boundary checks: tw_last is high exactly on accepted beats 32, 64, 96, 128, 160. tw_stage steps from 0 to 4 at those boundaries.
- abort at beat 50: the next cycle has tw_valid=0, busy=0 and no frame_done pulse. A new start then replays from address 0.
- start pulsed at beat 10 of a running frame: the frame is unaffected. rst=1 at beat 70: all outputs are 0 on the next cycle.
- With TW_SEQ_BITREV_EN: stage 3 order is 12,16,14,18,13,17,15,19 (4 repeats each) and stage 0 order is 0,2,1,3.
